bank_array: RTL

- Parametrised multi-bank scratchpad for the GEMM datapath. It is the successor to the single dual-port bank.
- NBANK single-port banks are low-order interleaved behind two independent requester ports, A and B.
- Each port uses a valid/ready request handshake. Bank conflicts are resolved by round-robin arbitration, and read latency is configurable.
- It feeds operand streams to the systolic array and accepts result write-back.

---
 rtl/bank_array_pkg.sv | 25 ++
 rtl/bank_ram.sv | 30 +++
 rtl/bank_array.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bank_array_pkg.sv
// Shared types for the interleaved bank array: arbitration priority, the
// per-port request bundle and the bank-select width helper.
package bank_array_pkg;

    // Request fields are carried at a fixed maximum width so the struct can
    // live in the package; the top slices back to its own parameter widths.
    localparam int REQ_ADDR_MAX = 32;
    localparam int REQ_DATA_MAX = 64;

    function automatic int bsel_w(input int nbank);
        return $clog2(nbank);
    endfunction

    typedef struct packed {
        logic                    we;
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [REQ_DATA_MAX-1:0] wdata;
    } req_t;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } rr_e;

endpackage

// File: rtl/bank_ram.sv
// Single-port bank RAM with a registered read port; contents are not reset.
module bank_ram #(
    parameter int A_WID = 10,
    parameter int D_WID = 8
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [A_WID-1:0] addr_i,
    input  logic [D_WID-1:0] wdata_i,
    output logic [D_WID-1:0] rdata_o
);

    logic [D_WID-1:0] mem_q [2**A_WID];
    logic [D_WID-1:0] rdata_q;

    // Read data only moves on a read, so a later write to this bank leaves it intact.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bank_array.sv
// Two-port, NBANK-way low-order interleaved scratchpad with round-robin bank
// arbitration and RD_LAT of 1 or 2. Define BANK_ARRAY_PERF_EN for conflict_cnt.
module bank_array
    import bank_array_pkg::*;
#(
    parameter int NBANK  = 16,
    parameter int A_WID  = 10,
    parameter int D_WID  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             a_req_valid,
    output logic                             a_req_ready,
    input  logic                             a_req_we,
    input  logic [A_WID+bsel_w(NBANK)-1:0]   a_req_addr,
    input  logic [D_WID-1:0]                 a_req_wdata,
    output logic                             a_rsp_valid,
    output logic [D_WID-1:0]                 a_rsp_rdata,
    input  logic                             b_req_valid,
    output logic                             b_req_ready,
    input  logic                             b_req_we,
    input  logic [A_WID+bsel_w(NBANK)-1:0]   b_req_addr,
    input  logic [D_WID-1:0]                 b_req_wdata,
    output logic                             b_rsp_valid,
    output logic [D_WID-1:0]                 b_rsp_rdata
`ifdef BANK_ARRAY_PERF_EN
    ,
    output logic [31:0]                      conflict_cnt
`endif
);

    localparam int BSEL_W = bsel_w(NBANK);

    logic [BSEL_W-1:0] a_bank, b_bank;
    logic              conflict, a_fire, b_fire;
    rr_e               rr_q, rr_d;
    req_t              a_req, b_req;
    logic [D_WID-1:0]  ram_rdata [NBANK];

    assign a_bank      = a_req_addr[BSEL_W-1:0];
    assign b_bank      = b_req_addr[BSEL_W-1:0];
    assign conflict    = a_req_valid && b_req_valid && (a_bank == b_bank);
    assign a_req_ready = !conflict || (rr_q == PRI_A);
    assign b_req_ready = !conflict || (rr_q == PRI_B);
    assign a_fire      = a_req_valid && a_req_ready;
    assign b_fire      = b_req_valid && b_req_ready;

    assign a_req = '{we: a_req_we, addr: REQ_ADDR_MAX'(a_req_addr), wdata: REQ_DATA_MAX'(a_req_wdata)};
    assign b_req = '{we: b_req_we, addr: REQ_ADDR_MAX'(b_req_addr), wdata: REQ_DATA_MAX'(b_req_wdata)};

    // Every conflict grants exactly one port, so priority always hands over to the loser.
    always_comb begin
        rr_d = rr_q;
        if (conflict) begin
            rr_d = (rr_q == PRI_A) ? PRI_B : PRI_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= PRI_A;
        end else begin
            rr_q <= rr_d;
        end
    end

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        logic sel_a, sel_b, unused_bank_req;
        req_t breq;

        assign sel_a           = a_fire && (a_bank == BSEL_W'(i));
        assign sel_b           = b_fire && (b_bank == BSEL_W'(i));
        assign breq            = sel_a ? a_req : b_req;
        assign unused_bank_req = ^breq;

        bank_ram #(
            .A_WID (A_WID),
            .D_WID (D_WID)
        ) u_ram (
            .clk     (clk),
            .en_i    (sel_a || sel_b),
            .we_i    (breq.we),
            .addr_i  (breq.addr[A_WID+BSEL_W-1:BSEL_W]),
            .wdata_i (breq.wdata[D_WID-1:0]),
            .rdata_o (ram_rdata[i])
        );
    end

    logic              a_v1_q, b_v1_q;
    logic [BSEL_W-1:0] a_bsel_q, b_bsel_q;
    logic [D_WID-1:0]  a_rd1, b_rd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_v1_q   <= 1'b0;
            b_v1_q   <= 1'b0;
            a_bsel_q <= '0;
            b_bsel_q <= '0;
        end else begin
            a_v1_q   <= a_fire && !a_req_we;
            b_v1_q   <= b_fire && !b_req_we;
            a_bsel_q <= a_bank;
            b_bsel_q <= b_bank;
        end
    end

    // Gating keeps the data outputs at zero out of reset, before any bank has been read.
    assign a_rd1 = a_v1_q ? ram_rdata[a_bsel_q] : '0;
    assign b_rd1 = b_v1_q ? ram_rdata[b_bsel_q] : '0;

    if (RD_LAT == 2) begin : g_lat2
        logic             a_v2_q, b_v2_q;
        logic [D_WID-1:0] a_rd2_q, b_rd2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_v2_q  <= 1'b0;
                b_v2_q  <= 1'b0;
                a_rd2_q <= '0;
                b_rd2_q <= '0;
            end else begin
                a_v2_q <= a_v1_q;
                b_v2_q <= b_v1_q;
                if (a_v1_q) a_rd2_q <= a_rd1;
                if (b_v1_q) b_rd2_q <= b_rd1;
            end
        end

        assign a_rsp_valid = a_v2_q;
        assign b_rsp_valid = b_v2_q;
        assign a_rsp_rdata = a_rd2_q;
        assign b_rsp_rdata = b_rd2_q;
    end else begin : g_lat1
        assign a_rsp_valid = a_v1_q;
        assign b_rsp_valid = b_v1_q;
        assign a_rsp_rdata = a_rd1;
        assign b_rsp_rdata = b_rd1;
    end

`ifdef BANK_ARRAY_PERF_EN
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
        end else if (conflict && (conflict_cnt_q != '1)) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
